fee_payment_unit: RTL and testbench
===================================

Name: fee_payment_unit

Overview:
- Exit-side fee calculation and payment stage of the parking garage controller.
- Sits directly downstream of the ticket FSM. The FSM pulses calc_start with the parking duration taken from a valid ticket.
- This block computes the fee, drives the BCD fee display and accumulates bill credit. It reports paid, cancelled or timed-out back to the FSM, which then opens the exit gate or lights the attendant lamp.

Parameters:
- DWIDTH, 16: width of parking_time_min.
- RATE, 2: fee units charged per started hour.
- MAX_FEE, 40: fee ceiling. Legal range 1..999.
- TIMEOUT_CYCLES, 500_000_000: idle-payment timeout in clk cycles (5 s at 100 MHz).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset. Asynchronous, active-low.
- calc_start  in  1  one-cycle pulse; samples parking_time_min.
- parking_time_min  in  DWIDTH  minutes parked. Valid while calc_start=1.
- bill_2  in  1  one-cycle pulse; 2-unit bill inserted.
- bill_4  in  1  one-cycle pulse; 4-unit bill inserted.
- cancel  in  1  abort the transaction and refund.
- busy  out  1  high in every state except IDLE.
- fee_valid  out  1  high while in WAIT_PAY.
- fee_bcd  out  12  fee as 3 BCD digits.
- remaining_bcd  out  12  amount still owed, 3 BCD digits.
- paid  out  1  one-cycle pulse when credit ≥ fee.
- pay_timeout  out  1  one-cycle pulse when payment times out.
- change_bcd  out  12  change or refund, 3 BCD digits.

Behaviour:
- Reset: state IDLE; every output and internal register is 0.
- States: IDLE, DIV, FEE, WAIT_PAY, DONE, ABORT.
- IDLE:
  - On calc_start, capture rem ← parking_time_min, h ← 0, credit ← 0, change ← 0, then go to DIV.
  - calc_start while busy=1 is ignored.
- DIV, one step per cycle:
  - If rem ≥ 60 and h*RATE < MAX_FEE: rem −= 60, h += 1.
  - Otherwise go to FEE.
- FEE (one cycle):
  - hours = h + (rem≠0 ? 1 : 0); if the result is 0, hours = 1.
  - fee = min(hours*RATE, MAX_FEE), 10-bit unsigned; products saturate and never wrap.
  - Go to WAIT_PAY; start the payment timer.
- Latency: calc_start sample edge to fee_valid high = min(floor(min/60), ceil(MAX_FEE/RATE)) + 3 edges.
- WAIT_PAY:
  - credit += 2*bill_2 + 4*bill_4. A simultaneous bill_2 and bill_4 credits 6.
  - Each accepted bill restarts the timer.
  - remaining = fee − credit, saturating at 0.
  - When credit ≥ fee: go to DONE, change = credit − fee.
  - When the timer reaches TIMEOUT_CYCLES with no bill: go to ABORT (timeout).
  - cancel: go to ABORT (cancel). If cancel and a bill arrive in the same cycle, the bill is credited first, then the abort is taken.
- DONE: paid=1 for one cycle, then IDLE.
- ABORT:
  - change = credit, i.e. a full refund.
  - pay_timeout=1 for one cycle, only on the timeout path.
  - Then IDLE.
- Bills outside WAIT_PAY are ignored and not credited.
- fee_bcd and change_bcd hold their values in IDLE until the next calc_start clears them.
- remaining_bcd reads 0 outside WAIT_PAY.
- cancel in DIV or FEE: return to IDLE, change = 0, no pulse.
- reset_n asserted mid-transaction: immediate return to reset state; credit is lost.
- Width rules: credit is 10 bits and cannot exceed MAX_FEE + 5. The timer is ceil(log2(TIMEOUT_CYCLES+1)) bits.

Decomposition:
- Package parking_pkg holds:
  - fee_state_t enum;
  - BCD_DIGITS = 3 and MINUTES_PER_HOUR = 60;
  - pure function bin2bcd(10-bit) → 12-bit BCD, used for fee_bcd, remaining_bcd and change_bcd.
- Sub-module pay_timer: down-counter with inputs load and run, output expired, parameter TIMEOUT_CYCLES.

Test Plan:
- parking_time_min=0, calc_start → fee_valid after 3 edges, fee_bcd=0x002, remaining_bcd=0x002. Then bill_2 → paid pulse, change_bcd=0x000.
- min=125 → fee_bcd=0x006 at 5 edges. bill_4 → remaining_bcd=0x002. bill_4 → paid, change_bcd=0x002.
- min=5000 → DIV exits at h=20, fee_bcd=0x040, latency 23 edges, no wrap.
- min=60, then bill_2 and bill_4 in the same cycle → credit 6, paid, change_bcd=0x004. A further bill_4 after paid is not credited.
- TIMEOUT_CYCLES=100, min=125, bill_2 at cycle 50, then nothing → pay_timeout exactly 100 cycles after that bill, change_bcd=0x002, busy=0.
- Robustness → calc_start during DIV is ignored; cancel in WAIT_PAY after bill_4 gives a refund of change_bcd=0x004 with no paid pulse; reset_n low mid-WAIT_PAY clears all outputs asynchronously.

Source files
------------

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Package     : parking_pkg
// Description : Shared types, constants and helpers for the exit-side fee and
//               payment stage of the parking garage controller.
// Contents    : fee_state_t  - fee/payment FSM state encoding
//               BCD_DIGITS   - digits on every BCD display output
//               MINUTES_PER_HOUR
//               bin2bcd()    - 10-bit binary to 3-digit packed BCD
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

  localparam int BCD_DIGITS       = 3;
  localparam int MINUTES_PER_HOUR = 60;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DIV      = 3'd1,
    ST_FEE      = 3'd2,
    ST_WAIT_PAY = 3'd3,
    ST_DONE     = 3'd4,
    ST_ABORT    = 3'd5
  } fee_state_t;

  // Shift-and-add-3 conversion. Only three digits are produced, so values
  // above 999 wrap modulo 1000 on the display.
  function automatic logic [4*BCD_DIGITS-1:0] bin2bcd(input logic [9:0] bin);
    logic [21:0] sr;
    sr = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (sr[13:10] >= 4'd5) sr[13:10] = sr[13:10] + 4'd3;
      if (sr[17:14] >= 4'd5) sr[17:14] = sr[17:14] + 4'd3;
      if (sr[21:18] >= 4'd5) sr[21:18] = sr[21:18] + 4'd3;
      sr = sr << 1;
    end
    return sr[21:10];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pay_timer.sv
`default_nettype none
// ============================================================================
// Module      : pay_timer
// Description : Idle-payment watchdog. A load restarts the count; while run
//               is high the count decrements to zero. expired is high once
//               TIMEOUT_CYCLES run cycles have elapsed since the last load.
// Ports       : clk, reset_n (async, active-low)
//               load    - restart the timeout window
//               run     - count enable
//               expired - window has elapsed (qualified by run)
// Revision    : 1.0 - initial release
// ============================================================================
module pay_timer #(
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int                 c_CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  // Reload with one less than the window: the cycle that observes zero is
  // the last cycle of the window, so the owner reacts exactly on time.
  localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  logic [c_CNT_W-1:0] count_q;
  logic [c_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = c_RELOAD;
    end else if (run && (count_q != '0)) begin
      count_d = count_q - c_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fee_payment_unit.sv
`default_nettype none
// ============================================================================
// Module      : fee_payment_unit
// Description : Exit-side fee calculation and payment stage. Converts parking
//               minutes into a fee (RATE per started hour, capped at MAX_FEE),
//               collects 2- and 4-unit bills and reports paid / cancelled /
//               timed-out back to the ticket FSM.
// Ports       : clk, reset_n (async, active-low)
//               calc_start, parking_time_min - start a fee calculation
//               bill_2, bill_4, cancel       - payment inputs
//               busy, fee_valid, paid, pay_timeout - status
//               fee_bcd, remaining_bcd, change_bcd - 3-digit BCD displays
// Revision    : 1.0 - initial release
// ============================================================================
module fee_payment_unit
  import parking_pkg::*;
#(
  parameter int DWIDTH         = 16,
  parameter int RATE           = 2,
  parameter int MAX_FEE        = 40,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    calc_start,
  input  logic [DWIDTH-1:0]       parking_time_min,
  input  logic                    bill_2,
  input  logic                    bill_4,
  input  logic                    cancel,
  output logic                    busy,
  output logic                    fee_valid,
  output logic [4*BCD_DIGITS-1:0] fee_bcd,
  output logic [4*BCD_DIGITS-1:0] remaining_bcd,
  output logic                    paid,
  output logic                    pay_timeout,
  output logic [4*BCD_DIGITS-1:0] change_bcd
);

  localparam logic [9:0]        c_MAX_FEE  = 10'(MAX_FEE);
  localparam logic [DWIDTH-1:0] c_MIN_HOUR = DWIDTH'(MINUTES_PER_HOUR);

  fee_state_t        state_q,   state_d;
  logic [DWIDTH-1:0] rem_q,     rem_d;
  logic [9:0]        hours_q,   hours_d;
  logic [9:0]        credit_q,  credit_d;
  logic [9:0]        fee_q,     fee_d;
  logic [9:0]        change_q,  change_d;
  logic              timeout_q, timeout_d;

  logic [9:0]  bill_amt;
  logic [9:0]  credit_sum;
  logic [9:0]  owed;
  logic [31:0] hour_cost;
  logic [31:0] hours_total;
  logic [31:0] fee_raw;
  logic [9:0]  fee_sat;
  logic        timer_load;
  logic        timer_run;
  logic        timer_expired;

  // 2*bill_2 + 4*bill_4; both together credit 6.
  assign bill_amt   = {7'd0, bill_4, bill_2, 1'b0};
  assign credit_sum = credit_q + bill_amt;

  // 32-bit arithmetic so the hour/rate product never wraps before the cap.
  assign hour_cost = 32'(hours_q) * 32'(RATE);

  always_comb begin
    hours_total = 32'(hours_q) + ((rem_q != '0) ? 32'd1 : 32'd0);
    if (hours_total == 32'd0) begin
      hours_total = 32'd1;
    end
    fee_raw = hours_total * 32'(RATE);
    fee_sat = (fee_raw > 32'(MAX_FEE)) ? c_MAX_FEE : fee_raw[9:0];
  end

  assign timer_run = (state_q == ST_WAIT_PAY);

  pay_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_pay_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (timer_load),
    .run    (timer_run),
    .expired(timer_expired)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      hours_q   <= '0;
      credit_q  <= '0;
      fee_q     <= '0;
      change_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      hours_q   <= hours_d;
      credit_q  <= credit_d;
      fee_q     <= fee_d;
      change_q  <= change_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    hours_d    = hours_q;
    credit_d   = credit_q;
    fee_d      = fee_q;
    change_d   = change_q;
    timeout_d  = timeout_q;
    timer_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (calc_start) begin
          rem_d     = parking_time_min;
          hours_d   = '0;
          credit_d  = '0;
          fee_d     = '0;
          change_d  = '0;
          timeout_d = 1'b0;
          state_d   = ST_DIV;
        end
      end

      // Repeated subtraction, one hour per cycle. Stops early once the
      // whole hours alone already reach the cap, bounding the latency.
      ST_DIV: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if ((rem_q >= c_MIN_HOUR) && (hour_cost < 32'(MAX_FEE))) begin
          rem_d   = rem_q - c_MIN_HOUR;
          hours_d = hours_q + 10'd1;
        end else begin
          state_d = ST_FEE;
        end
      end

      ST_FEE: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          fee_d      = fee_sat;
          timer_load = 1'b1;
          state_d    = ST_WAIT_PAY;
        end
      end

      // A bill arriving with cancel is credited first so the refund
      // returns everything inserted, including that bill.
      ST_WAIT_PAY: begin
        credit_d = credit_sum;
        if (bill_amt != '0) begin
          timer_load = 1'b1;
        end
        if (cancel) begin
          change_d = credit_sum;
          state_d  = ST_ABORT;
        end else if (credit_sum >= fee_q) begin
          change_d = credit_sum - fee_q;
          state_d  = ST_DONE;
        end else if ((bill_amt == '0) && timer_expired) begin
          change_d  = credit_q;
          timeout_d = 1'b1;
          state_d   = ST_ABORT;
        end
      end

      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    owed          = (credit_q >= fee_q) ? 10'd0 : (fee_q - credit_q);
    busy          = (state_q != ST_IDLE);
    fee_valid     = (state_q == ST_WAIT_PAY);
    paid          = (state_q == ST_DONE);
    pay_timeout   = (state_q == ST_ABORT) && timeout_q;
    fee_bcd       = bin2bcd(fee_q);
    change_bcd    = bin2bcd(change_q);
    remaining_bcd = (state_q == ST_WAIT_PAY) ? bin2bcd(owed) : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_fee_payment_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fee_payment_unit
// Description : Scoreboard bench for fee_payment_unit. The driver pushes the
//               expected fee, remaining-amount and end-of-transaction events
//               into queues; a monitor pops and compares them whenever the
//               unit presents the corresponding output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fee_payment_unit;

  localparam int c_DW   = 16;
  localparam int c_RATE = 2;
  localparam int c_MAX  = 40;
  localparam int c_TO   = 100;

  localparam int K_PAID    = 0;
  localparam int K_CANCEL  = 1;
  localparam int K_TIMEOUT = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            calc_start = 1'b0;
  logic [c_DW-1:0] parking_time_min = '0;
  logic            bill_2 = 1'b0;
  logic            bill_4 = 1'b0;
  logic            cancel = 1'b0;
  logic            busy, fee_valid, paid, pay_timeout;
  logic [11:0]     fee_bcd, remaining_bcd, change_bcd;

  fee_payment_unit #(
    .DWIDTH(c_DW), .RATE(c_RATE), .MAX_FEE(c_MAX), .TIMEOUT_CYCLES(c_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .calc_start(calc_start),
    .parking_time_min(parking_time_min), .bill_2(bill_2), .bill_4(bill_4),
    .cancel(cancel), .busy(busy), .fee_valid(fee_valid), .fee_bcd(fee_bcd),
    .remaining_bcd(remaining_bcd), .paid(paid), .pay_timeout(pay_timeout),
    .change_bcd(change_bcd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int fee; int edge_at; } fee_exp_t;
  typedef struct { int kind; int change; int edge_at; } end_exp_t;

  fee_exp_t fee_exp_q[$];
  end_exp_t end_exp_q[$];
  int       rem_exp_q[$];
  bit       mon_en = 1'b0;

  // Reference model state
  int cur_fee = 0;
  int credit = 0;
  int last_load = 0;
  int last_change = 0;
  bit in_pay = 1'b0;

  function automatic int to_bcd(input int v);
    return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Fee from the tariff rules: started hours, at least one, capped.
  function automatic int model_fee(input int m);
    int hrs;
    hrs = (m + 59) / 60;
    if (hrs == 0) hrs = 1;
    return (hrs * c_RATE > c_MAX) ? c_MAX : hrs * c_RATE;
  endfunction

  function automatic int model_lat(input int m);
    int h;
    int cap;
    h   = m / 60;
    cap = (c_MAX + c_RATE - 1) / c_RATE;
    return ((h < cap) ? h : cap) + 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_end(input int kind, input int change, input int edge_at);
    end_exp_t e;
    e.kind = kind;
    e.change = change;
    e.edge_at = edge_at;
    end_exp_q.push_back(e);
  endfunction

  // ---------------------------------------------------------------- monitor
  bit          p_fv, p_busy, p_paid, p_to;
  logic [11:0] p_rem;

  task automatic end_event(input int act_kind);
    end_exp_t e;
    if (end_exp_q.size() == 0) begin
      chk("unexpected_end_event", act_kind, -1);
    end else begin
      e = end_exp_q.pop_front();
      chk("end_kind", act_kind, e.kind);
      chk("change_bcd", int'(change_bcd), to_bcd(e.change));
      if (e.edge_at >= 0) chk("end_edge", cyc, e.edge_at);
    end
  endtask

  always @(negedge clk) begin : mon
    fee_exp_t f;
    int r;
    if (!reset_n || !mon_en) begin
      p_fv = 1'b0; p_busy = 1'b0; p_paid = 1'b0; p_to = 1'b0; p_rem = '0;
    end else begin
      if (fee_valid && !p_fv) begin
        if (fee_exp_q.size() == 0) begin
          chk("unexpected_fee_valid", 1, 0);
        end else begin
          f = fee_exp_q.pop_front();
          chk("fee_bcd", int'(fee_bcd), to_bcd(f.fee));
          chk("remaining_at_start", int'(remaining_bcd), to_bcd(f.fee));
          chk("fee_latency_edge", cyc, f.edge_at);
        end
      end
      if (fee_valid && p_fv && (remaining_bcd != p_rem)) begin
        if (rem_exp_q.size() == 0) begin
          chk("unexpected_remaining_change", int'(remaining_bcd), int'(p_rem));
        end else begin
          r = rem_exp_q.pop_front();
          chk("remaining_bcd", int'(remaining_bcd), to_bcd(r));
        end
      end
      if (paid) end_event(K_PAID);
      if (pay_timeout) end_event(K_TIMEOUT);
      if (!busy && p_busy && !p_paid && !p_to) end_event(K_CANCEL);
      p_fv = fee_valid; p_busy = busy; p_paid = paid; p_to = pay_timeout;
      p_rem = remaining_bcd;
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_txn(input int m, input bit early_cancel, input bit dbl_start);
    int s;
    int lat;
    int n;
    fee_exp_t f;
    calc_start = 1'b1;
    parking_time_min = c_DW'(m);
    s = cyc + 1;
    lat = model_lat(m);
    credit = 0;
    last_change = 0;
    tick();
    calc_start = 1'b0;
    if (early_cancel) begin
      cancel = 1'b1;
      push_end(K_CANCEL, 0, -1);
      cur_fee = 0;
      in_pay = 1'b0;
      tick();
      cancel = 1'b0;
      return;
    end
    cur_fee = model_fee(m);
    f.fee = cur_fee;
    f.edge_at = s + lat - 1;
    fee_exp_q.push_back(f);
    last_load = s + lat - 1;
    in_pay = 1'b1;
    if (dbl_start) begin
      tick();
      calc_start = 1'b1;
      parking_time_min = '0;
      tick();
      calc_start = 1'b0;
    end
    n = 0;
    while (!fee_valid && n < 100) begin
      tick();
      n++;
    end
    if (!fee_valid) begin
      chk("fee_valid_wait_expired", 0, 1);
      in_pay = 1'b0;
    end
  endtask

  task automatic bill(input bit b2, input bit b4, input bit c);
    int e;
    int amt;
    amt = (b2 ? 2 : 0) + (b4 ? 4 : 0);
    bill_2 = b2;
    bill_4 = b4;
    cancel = c;
    e = cyc + 1;
    tick();
    bill_2 = 1'b0;
    bill_4 = 1'b0;
    cancel = 1'b0;
    if (in_pay) begin
      credit += amt;
      if (c) begin
        last_change = credit;
        push_end(K_CANCEL, credit, -1);
        in_pay = 1'b0;
      end else if (credit >= cur_fee) begin
        last_change = credit - cur_fee;
        push_end(K_PAID, last_change, e);
        in_pay = 1'b0;
      end else if (amt > 0) begin
        rem_exp_q.push_back(cur_fee - credit);
        last_load = e;
      end
    end
  endtask

  // A bill that keeps the credit below the fee, or no bill if none fits.
  task automatic bill_under(input bit c);
    if (credit + 4 < cur_fee && $urandom_range(0, 1) == 1) bill(1'b0, 1'b1, c);
    else if (credit + 2 < cur_fee) bill(1'b1, 1'b0, c);
    else bill(1'b0, 1'b0, c);
  endtask

  task automatic pay_rest();
    bit b2;
    bit b4;
    int guard;
    guard = 0;
    while (in_pay && guard < 50) begin
      idle($urandom_range(0, 3));
      b2 = 1'($urandom_range(0, 1));
      b4 = b2 ? 1'($urandom_range(0, 1)) : 1'b1;
      bill(b2, b4, 1'b0);
      guard++;
    end
  endtask

  task automatic wait_timeout();
    push_end(K_TIMEOUT, credit, last_load + c_TO);
    last_change = credit;
    in_pay = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk("busy_returns_low", int'(busy), 0);
    chk("fee_bcd_held", int'(fee_bcd), to_bcd(cur_fee));
    chk("change_bcd_held", int'(change_bcd), to_bcd(last_change));
    chk("remaining_idle", int'(remaining_bcd), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fee_valid"}, int'(fee_valid), 0);
    chk({tag, "_paid"}, int'(paid), 0);
    chk({tag, "_pay_timeout"}, int'(pay_timeout), 0);
    chk({tag, "_fee_bcd"}, int'(fee_bcd), 0);
    chk({tag, "_remaining_bcd"}, int'(remaining_bcd), 0);
    chk({tag, "_change_bcd"}, int'(change_bcd), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int m;
    int mode;
    int nb;
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk_all_zero("post_reset");
    mon_en = 1'b1;

    // 0 minutes: minimum one-hour fee, exact payment
    start_txn(0, 1'b0, 1'b0);
    bill(1'b1, 1'b0, 1'b0);
    wait_idle(20);

    // 125 minutes: fee 6, overpay by 2
    start_txn(125, 1'b0, 1'b0);
    bill(1'b0, 1'b1, 1'b0);
    idle(1);
    bill(1'b0, 1'b1, 1'b0);
    wait_idle(20);

    // 5000 minutes: capped fee, capped latency
    start_txn(5000, 1'b0, 1'b0);
    repeat (10) bill(1'b0, 1'b1, 1'b0);
    wait_idle(20);

    // Simultaneous bills, then a late bill that must not be credited
    start_txn(60, 1'b0, 1'b0);
    bill(1'b1, 1'b1, 1'b0);
    wait_idle(20);
    bill(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("change_after_late_bill", int'(change_bcd), to_bcd(4));
    chk("busy_after_late_bill", int'(busy), 0);

    // Timeout measured from the last bill
    start_txn(125, 1'b0, 1'b0);
    idle(48);
    bill(1'b1, 1'b0, 1'b0);
    wait_timeout();
    wait_idle(c_TO + 50);

    // calc_start during DIV is ignored
    start_txn(5000, 1'b0, 1'b1);
    pay_rest();
    wait_idle(20);

    // Cancel in WAIT_PAY refunds the inserted bill
    start_txn(125, 1'b0, 1'b0);
    bill(1'b0, 1'b1, 1'b0);
    idle(2);
    bill(1'b0, 1'b0, 1'b1);
    wait_idle(20);

    // Cancel during DIV: no pulse, nothing to refund
    start_txn(300, 1'b1, 1'b0);
    wait_idle(20);

    // Cancel together with a bill: bill is part of the refund
    start_txn(125, 1'b0, 1'b0);
    bill(1'b1, 1'b0, 1'b0);
    bill(1'b1, 1'b0, 1'b1);
    wait_idle(20);

    // Asynchronous reset in WAIT_PAY
    start_txn(125, 1'b0, 1'b0);
    bill(1'b0, 1'b1, 1'b0);
    idle(2);
    mon_en = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    fee_exp_q.delete();
    end_exp_q.delete();
    rem_exp_q.delete();
    in_pay = 1'b0;
    cur_fee = 0;
    last_change = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Randomized transactions
    repeat (30) begin
      case ($urandom_range(0, 3))
        0:       m = int'($urandom_range(0, 59));
        1:       m = int'($urandom_range(0, 400));
        2:       m = int'($urandom_range(0, 65535));
        default: m = 60 * int'($urandom_range(0, 25));
      endcase
      mode = int'($urandom_range(0, 9));
      if (mode == 9) begin
        start_txn(m, 1'b1, 1'b0);
        wait_idle(20);
      end else begin
        start_txn(m, 1'b0, 1'b0);
        if (mode <= 5) begin
          pay_rest();
          wait_idle(20);
        end else if (mode <= 7) begin
          nb = int'($urandom_range(0, 2));
          repeat (nb) begin
            idle($urandom_range(0, 3));
            bill_under(1'b0);
          end
          bill_under(1'b1);
          wait_idle(20);
        end else begin
          nb = int'($urandom_range(0, 2));
          repeat (nb) begin
            idle($urandom_range(0, 5));
            bill_under(1'b0);
          end
          wait_timeout();
          wait_idle(c_TO + 50);
        end
      end
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("fee_queue_drained", fee_exp_q.size(), 0);
    chk("end_queue_drained", end_exp_q.size(), 0);
    chk("remaining_queue_drained", rem_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
